// File: rtl/cla_pipe_addsub_pkg.sv
// Shared constants and the elaboration-time geometry check for the pipelined CLA adder/subtractor.
package cla_pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // WIDTH must split evenly into STAGES slices, and each slice evenly into GROUP-bit groups
  function automatic bit cfg_ok(input int width, input int stages, input int group);
    if (stages < 1 || stages > width || group < 1) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    return ((width / stages) % group) == 0;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub; master drives operands, slave is the adder.
interface cla_pipe_addsub_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_addsub_slice.sv
// Combinational SW-bit carry-lookahead slice: GROUP-bit lookahead groups, carry ripples only between groups.
module cla_slice #(
    parameter int SW    = 8,
    parameter int GROUP = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          c_msb
);
    localparam int NG = SW / GROUP;

    logic [SW-1:0] w_g;
    logic [SW-1:0] w_p;
    logic [SW:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        logic [SW:0] c;
        logic        gg;
        logic        gp;
        c    = '0;
        gg   = 1'b0;
        gp   = 1'b1;
        c[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            // gg/gp are the prefix group generate/propagate; every bit carry comes from the group carry-in
            for (int i = 0; i < GROUP; i++) begin
                gg = w_g[j*GROUP+i] | (w_p[j*GROUP+i] & gg);
                gp = gp & w_p[j*GROUP+i];
                c[j*GROUP+i+1] = gg | (gp & c[j*GROUP]);
            end
        end
        w_c = c;
    end

    assign s     = w_p ^ w_c[SW-1:0];
    assign co    = w_c[SW];
    assign c_msb = w_c[SW-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/sub: one CLA slice per stage, slice carry registered between stages, global-stall handshake.
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_pipe_addsub_if.slave     bus
);
    localparam int SW = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES, GROUP)) begin : g_cfg_err
        $error("cla_pipe_addsub: WIDTH/STAGES/GROUP geometry is invalid");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic             w_c0;
    logic             r_ovf;
    logic             r_zero;

    // No bubble compaction: the whole pipe moves or the whole pipe holds
    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign w_bx         = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    assign w_c0         = (bus.sub == OP_SUB) ? 1'b1 : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = (k + 1) * SW;

        logic [SW-1:0] w_sa, w_sb, w_s;
        logic          w_ci, w_co, w_cmsb, w_vin;
        logic [RW-1:0] w_res;
        logic [RW-1:0] r_res;
        logic          r_c;
        logic          r_vld;

        if (k == 0) begin : g_src
            assign w_sa  = bus.a[SW-1:0];
            assign w_sb  = w_bx[SW-1:0];
            assign w_ci  = w_c0;
            assign w_vin = bus.in_valid;
            assign w_res = w_s;
        end else begin : g_src
            assign w_sa  = g_stage[k-1].g_fwd.r_a[SW-1:0];
            assign w_sb  = g_stage[k-1].g_fwd.r_b[SW-1:0];
            assign w_ci  = g_stage[k-1].r_c;
            assign w_vin = g_stage[k-1].r_vld;
            assign w_res = {w_s, g_stage[k-1].r_res};
        end

        cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
            .a     (w_sa),
            .b     (w_sb),
            .ci    (w_ci),
            .s     (w_s),
            .co    (w_co),
            .c_msb (w_cmsb)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_res <= '0;
            end else if (w_adv) begin
                r_vld <= w_vin;
                r_c   <= w_co;
                r_res <= w_res;
            end
        end

        // Operand bits not yet consumed travel down with the beat (B already inverted for subtract)
        if (k < STAGES - 1) begin : g_fwd
            localparam int HW = WIDTH - RW;
            logic [HW-1:0] w_na, w_nb;
            logic [HW-1:0] r_a, r_b;
            if (k == 0) begin : g_nxt
                assign w_na = bus.a[WIDTH-1:SW];
                assign w_nb = w_bx[WIDTH-1:SW];
            end else begin : g_nxt
                assign w_na = g_stage[k-1].g_fwd.r_a[HW+SW-1:SW];
                assign w_nb = g_stage[k-1].g_fwd.r_b[HW+SW-1:SW];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_na;
                    r_b <= w_nb;
                end
            end
        end

        if (k == STAGES - 1) begin : g_flags
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= w_co ^ w_cmsb;
                    r_zero <= (w_res == '0);
                end
            end
        end else begin : g_sink
            logic w_unused_cmsb;
            assign w_unused_cmsb = w_cmsb;
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].r_vld;
    assign bus.sum       = g_stage[STAGES-1].r_res;
    assign bus.cout      = g_stage[STAGES-1].r_c;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule
